// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_pkg;

    localparam int unsigned DIV_N_DEFAULT = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division row: trial-subtract the divisor from the shifted
// partial remainder and keep the difference when it does not go negative.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned N = DIV_N_DEFAULT
) (
    input  logic [N:0]   rem,
    input  logic [N-1:0] divisor,
    output logic [N:0]   rem_next_c,
    output logic         qbit_c
);

    localparam int unsigned DW = N + 2;

    logic [N+1:0] diff_c;

    // One extra bit above the remainder width acts as the borrow/sign bit.
    assign diff_c     = DW'(rem) - DW'(divisor);
    assign qbit_c     = ~diff_c[N+1];
    assign rem_next_c = qbit_c ? diff_c[N:0] : rem;

endmodule

// File: rtl/div_sequential.sv
// Sequential unsigned divider: one restoring iteration per clock, MSB first.
// Divide-by-zero short-circuits straight to DONE with q=all ones, r=x.
module div_sequential
    import div_pkg::*;
#(
    parameter int unsigned N = DIV_N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic [N-1:0] q,
    output logic [N-1:0] r,
    output logic         busy,
    output logic         done,
    output logic         dbz
);

    localparam int unsigned RW = N + 1;
    localparam int unsigned CW = $clog2(N);

    div_state_t   state;
    logic [N-1:0] quo_sh;      // dividend bits shift out the top, quotient bits shift in below
    logic [N-1:0] divisor;
    logic [N:0]   rem;
    logic [CW-1:0] cnt;

    logic [N:0]   rem_shift_c;
    logic [N:0]   rem_next_c;
    logic         qbit_c;
    logic [N-1:0] quo_next_c;

    // Bring the next dividend bit into the partial remainder.
    assign rem_shift_c = RW'({rem, quo_sh[N-1]});
    assign quo_next_c  = {quo_sh[N-2:0], qbit_c};

    div_step #(
        .N(N)
    ) u_step (
        .rem       (rem_shift_c),
        .divisor   (divisor),
        .rem_next_c(rem_next_c),
        .qbit_c    (qbit_c)
    );

    // Control FSM with datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            quo_sh  <= '0;
            divisor <= '0;
            rem     <= '0;
            cnt     <= '0;
            q       <= '0;
            r       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dbz     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        quo_sh  <= x;
                        divisor <= y;
                        rem     <= '0;
                        cnt     <= '0;
                        if (y == '0) begin
                            state <= DONE;
                            q     <= '1;
                            r     <= x;
                            dbz   <= 1'b1;
                            done  <= 1'b1;
                        end else begin
                            state <= CALC;
                            busy  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    rem    <= rem_next_c;
                    quo_sh <= quo_next_c;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        q     <= quo_next_c;
                        r     <= rem_next_c[N-1:0];
                        dbz   <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequential.sv
// Self-checking bench for div_sequential (N=10): directed table, multi-cycle
// corner sequences, and a randomized regression against an arithmetic model.
module tb_div_sequential;

    localparam int unsigned N      = 10;
    localparam int unsigned BOUND  = 40;
    localparam int unsigned NRAND  = 10000;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dbz;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         busy;
    logic         done;
    logic         dbz;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    div_sequential #(
        .N(N)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .x    (x),
        .y    (y),
        .q    (q),
        .r    (r),
        .busy (busy),
        .done (done),
        .dbz  (dbz)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // Reference: plain integer division, with the divide-by-zero convention.
    function automatic logic [2*N:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
        if (b == '0) return {{N{1'b1}}, a, 1'b1};
        return {N'(a / b), N'(a % b), 1'b0};
    endfunction

    function automatic logic [N-1:0] rand_x();
        if ($urandom_range(0, 3) == 0) return N'($urandom_range(0, 20));
        return N'($urandom);
    endfunction

    function automatic logic [N-1:0] rand_y();
        int unsigned sel = $urandom_range(0, 5);
        if (sel < 2) return '0;
        if (sel == 2) return N'($urandom_range(1, 15));
        return N'($urandom);
    endfunction

    // Called at a negedge; drives one request and waits (bounded) for done.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          output int lat, output int busy_cycles, output logic [2*N:0] res);
        start = 1'b1;
        x = a;
        y = b;
        lat = 0;
        busy_cycles = 0;
        res = '0;
        for (int c = 1; c <= int'(BOUND); c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                x = N'($urandom);
                y = N'($urandom);
            end
            if (busy) busy_cycles++;
            if (done) begin
                lat = c;
                res = {q, r, dbz};
                break;
            end
        end
        if (lat == 0) begin
            total++;
            bad++;
            $display("FAIL op_timeout: got=no done expected=done within %0d cycles", BOUND);
        end
    endtask

    vec_t         vecs[8];
    int           lat;
    int           bcnt;
    int           done_cnt;
    int           done_at;
    logic [2*N:0] res;
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    logic         seen;

    initial begin
        vecs[0] = '{a: 10'd1000, b: 10'd7,    q: 10'd142,  r: 10'd6,    dbz: 1'b0};
        vecs[1] = '{a: 10'd5,    b: 10'd0,    q: 10'd1023, r: 10'd5,    dbz: 1'b1};
        vecs[2] = '{a: 10'd1023, b: 10'd1,    q: 10'd1023, r: 10'd0,    dbz: 1'b0};
        vecs[3] = '{a: 10'd3,    b: 10'd1000, q: 10'd0,    r: 10'd3,    dbz: 1'b0};
        vecs[4] = '{a: 10'd0,    b: 10'd9,    q: 10'd0,    r: 10'd0,    dbz: 1'b0};
        vecs[5] = '{a: 10'd10,   b: 10'd10,   q: 10'd1,    r: 10'd0,    dbz: 1'b0};
        vecs[6] = '{a: 10'd1023, b: 10'd1023, q: 10'd1,    r: 10'd0,    dbz: 1'b0};
        vecs[7] = '{a: 10'd0,    b: 10'd0,    q: 10'd1023, r: 10'd0,    dbz: 1'b1};

        rst = 1'b1;
        start = 1'b1;
        x = 10'd77;
        y = 10'd3;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({q, r, busy, done, dbz}), 64'(0));

        // Release reset and request on the very first edge afterwards.
        rst = 1'b0;
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, lat, bcnt, res);
            check($sformatf("vec%0d_result", i), 64'(res),
                  64'({vecs[i].q, vecs[i].r, vecs[i].dbz}));
            check($sformatf("vec%0d_latency", i), 64'(lat),
                  64'((vecs[i].b == '0) ? 1 : N + 1));
            check($sformatf("vec%0d_busy_cycles", i), 64'(bcnt),
                  64'((vecs[i].b == '0) ? 0 : N));
            @(negedge clk);
            check($sformatf("vec%0d_after_done", i), 64'({done, busy, q, r, dbz}),
                  64'({1'b0, 1'b0, vecs[i].q, vecs[i].r, vecs[i].dbz}));
        end

        // Second start raised mid-calculation must be ignored.
        start = 1'b1;
        x = 10'd100;
        y = 10'd3;
        done_cnt = 0;
        done_at = 0;
        res = '0;
        for (int c = 1; c <= int'(N) + 4; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == 4) begin
                start = 1'b1;
                x = 10'd50;
                y = 10'd5;
            end
            if (done) begin
                done_cnt++;
                done_at = c;
                res = {q, r, dbz};
                start = 1'b0;
            end
        end
        check("midcalc_start_result", 64'(res), 64'({10'd33, 10'd1, 1'b0}));
        check("midcalc_start_done_count", 64'(done_cnt), 64'(1));
        check("midcalc_start_done_cycle", 64'(done_at), 64'(N + 1));
        check("midcalc_start_idle_after", 64'({busy, done, q, r}), 64'({1'b0, 1'b0, 10'd33, 10'd1}));

        // Reset in the middle of CALC aborts the operation.
        start = 1'b1;
        x = 10'd1000;
        y = 10'd7;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        check("abort_busy_before_rst", 64'(busy), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        check("abort_outputs_cleared", 64'({q, r, busy, done, dbz}), 64'(0));
        rst = 1'b0;
        run_op(10'd64, 10'd8, lat, bcnt, res);
        check("abort_fresh_result", 64'(res), 64'({10'd8, 10'd0, 1'b0}));
        check("abort_fresh_latency", 64'(lat), 64'(N + 1));
        @(negedge clk);

        // Random regression, start held high so each result is followed by the next request.
        ra = rand_x();
        rb = rand_y();
        x = ra;
        y = rb;
        start = 1'b1;
        for (int k = 0; k < int'(NRAND); k++) begin
            seen = 1'b0;
            for (int c = 1; c <= int'(BOUND); c++) begin
                @(negedge clk);
                if (done) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen) begin
                total++;
                bad++;
                $display("FAIL rand_timeout: got=no done expected=done for op %0d", k);
                break;
            end
            check($sformatf("rand_x%0d_y%0d", ra, rb), 64'({q, r, dbz}), 64'(model(ra, rb)));
            ra = rand_x();
            rb = rand_y();
            x = ra;
            y = rb;
        end
        start = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
